fir_tap_scheduler: RTL and testbench
====================================

// Module: fir_tap_scheduler
// PURPOSE
// - Sequences the FIR datapath of the audio engine: accepts one ADC sample per frame and holds the tap history.
// - Steps a single shared multiply-accumulate over all taps, reading coefficients from the coefficient bank.
// - Emits one scaled FIR result per accepted sample toward the DAC path.
// - Sits between the I2S ADC deserialiser (sampleIn/sampleValid) and the DAC serialiser; the coefficient bank is the SPI-loaded register file.
// PARAMETERS
// - NUM_TAPS    5   number of taps / history depth (>=2)
// - DATA_WIDTH  16  signed sample width, in and out
// - COEFF_WIDTH 16  signed coefficient width
// - COEFF_FRAC  15  fractional bits of coefficients; final right shift
// - ADDR_WIDTH  $clog2(NUM_TAPS)  coefficient/tap index width
// PORTS
// - clk          in   1            system clock
// - reset        in   1            synchronous, active-low reset
// - sampleIn     in   DATA_WIDTH   signed ADC sample
// - sampleValid  in   1            one-cycle strobe, sampleIn valid
// - coeffAddr    out  ADDR_WIDTH   tap index into coefficient bank
// - coeffData    in   COEFF_WIDTH  signed coefficient for coeffAddr, combinational same-cycle return
// - firData      out  DATA_WIDTH   signed FIR result, held until next result
// - firValid     out  1            one-cycle strobe, firData updated
// - busy         out  1            high whenever state != IDLE
// - overrun      out  1            sticky: sample arrived while busy
// - overrunClear in   1            clears overrun
// BEHAVIOUR
// - Reset (reset==0 at clk edge) forces:
//   - state=IDLE; firData=0, firValid=0, busy=0, overrun=0, coeffAddr=0.
//   - Accumulator=0, all history slots=0, wrPtr=0.
// - FSM states: IDLE -> MAC -> DONE -> IDLE.
// - IDLE: on sampleValid, write hist[wrPtr]=sampleIn, tap=0, acc=0, go MAC.
// - MAC: one tap per cycle, k=0..NUM_TAPS-1.
//   - coeffAddr=k (registered).
//   - acc += hist[(wrPtr-k) mod NUM_TAPS] * coeffData.
//   - After k=NUM_TAPS-1, go DONE.
// - DONE: firData=result, firValid=1 for exactly this cycle, wrPtr+=1 (wraps NUM_TAPS-1 -> 0), go IDLE.
// - Latency: sampleValid at edge t -> firValid high in cycle t+NUM_TAPS+1; busy high t+1..t+NUM_TAPS+1.
// - Throughput: one sample per NUM_TAPS+2 cycles.
// - Arithmetic:
//   - Full-precision signed products.
//   - ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+$clog2(NUM_TAPS); no internal overflow.
//   - result = acc >>> COEFF_FRAC: arithmetic shift, truncation toward -inf, no rounding.
// - Boundary conditions:
//   - sampleValid while busy (MAC or DONE): sample dropped, history unchanged, overrun=1.
//   - Same-cycle overrun set and overrunClear: set wins.
//   - Reset mid-operation: abort immediately; no firValid for the aborted sample; history cleared.
// - coeffData is sampled only during MAC; the bank must not change while busy (the bank's contract, not checked here).
// CONFIGURATION
// - FIR_SATURATE_EN defined: result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
// - FIR_SATURATE_EN undefined: firData = low DATA_WIDTH bits of result (two's-complement wrap).
// TESTING (defaults; coefficient bank modelled in bench)
// - Impulse: coeffs all 0x4000; samples 0x4000,0,0,0,0,0 -> firData 0x2000 x5, then 0x0000.
// - Timing: sampleValid at cycle t -> firValid only at t+6 (1 cycle wide); busy=1 for t+1..t+6; coeffAddr steps 0..4 during t+1..t+5.
// - Overrun: second sampleValid at t+3 -> dropped, overrun=1, output unchanged. overrunClear at t+10 -> overrun=0.
//   - overrunClear and a new busy-time sampleValid in the same cycle -> overrun stays 1.
// - Pointer wrap: coeff[2]=0x4000, others 0; samples 2,4,...,14 -> outputs 0,0,1,2,3,4,5.
// - Saturation: coeffs 0x7FFF; five samples 0x7FFF -> 5th output 0x7FFF with FIR_SATURATE_EN, 0x7FF6 without.
//   - Five samples 0x8000 -> 0x8000 with FIR_SATURATE_EN.
// - Reset mid-MAC: reset=0 for one cycle at t+3 -> no firValid, busy=0, overrun=0.
//   - Impulse test then repeats with identical outputs.

Source files
------------

// File: rtl/fir_tap_scheduler.sv
// Sequential single-MAC FIR: stores the tap history and steps one tap per cycle.
// Optional build macro FIR_SATURATE_EN clamps the result instead of wrapping it.
module fir_tap_scheduler #(
    parameter int NUM_TAPS    = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 15,
    parameter int ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_WIDTH-1:0]  sampleIn,
    input  logic                          sampleValid,
    output logic        [ADDR_WIDTH-1:0]  coeffAddr,
    input  logic signed [COEFF_WIDTH-1:0] coeffData,
    output logic signed [DATA_WIDTH-1:0]  firData,
    output logic                          firValid,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          overrunClear
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(NUM_TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_e;

    state_e                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   hist_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]   hist_d [NUM_TAPS];
    logic        [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic        [ADDR_WIDTH-1:0]   tap_q, tap_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]   fir_data_q, fir_data_d;
    logic                           fir_valid_q, fir_valid_d;
    logic                           overrun_q, overrun_d;

    logic        [ADDR_WIDTH-1:0]   rd_idx;
    logic signed [DATA_WIDTH-1:0]   rd_sample;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic signed [DATA_WIDTH-1:0]   result_out;

    // Tap k reads the sample k frames older than the newest one at wr_ptr.
    always_comb begin
        if (wr_ptr_q >= tap_q) begin
            rd_idx = wr_ptr_q - tap_q;
        end else begin
            rd_idx = wr_ptr_q + (ADDR_WIDTH'(NUM_TAPS) - tap_q);
        end
        rd_sample = hist_q[rd_idx];
        product   = PROD_WIDTH'(rd_sample) * PROD_WIDTH'(coeffData);
        acc_sum   = acc_q + ACC_WIDTH'(product);
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] MAX_OUT =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_OUT =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] scaled;

    always_comb begin
        scaled = acc_sum >>> COEFF_FRAC;
        if (scaled > MAX_OUT) begin
            result_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (scaled < MIN_OUT) begin
            result_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            result_out = scaled[DATA_WIDTH-1:0];
        end
    end
`else
    // Low bits of the arithmetic shift are just a slice of the accumulator.
    assign result_out = acc_sum[COEFF_FRAC +: DATA_WIDTH];
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        wr_ptr_d    = wr_ptr_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        fir_data_d  = fir_data_q;
        fir_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (overrunClear) begin
            overrun_d = 1'b0;
        end
        if (sampleValid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sampleValid) begin
                    hist_d[wr_ptr_q] = sampleIn;
                    tap_d            = '0;
                    acc_d            = '0;
                    state_d          = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                if (tap_q == LAST_TAP) begin
                    tap_d       = '0;
                    fir_data_d  = result_out;
                    fir_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tap_d = tap_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the history is reset too, since a reset must not leak old samples into the next result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            fir_data_q  <= '0;
            fir_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            wr_ptr_q    <= wr_ptr_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            fir_data_q  <= fir_data_d;
            fir_valid_q <= fir_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign coeffAddr = tap_q;
    assign firData   = fir_data_q;
    assign firValid  = fir_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler with a modelled coefficient bank.
module tb_fir_tap_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sampleIn;
    logic               sampleValid;
    logic        [2:0]  coeffAddr;
    logic signed [15:0] coeffData;
    logic signed [15:0] firData;
    logic               firValid;
    logic               busy;
    logic               overrun;
    logic               overrunClear;

    logic signed [15:0] bank [5];
    int passed = 0;
    int failed = 0;
    int total  = 0;

    fir_tap_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .sampleIn     (sampleIn),
        .sampleValid  (sampleValid),
        .coeffAddr    (coeffAddr),
        .coeffData    (coeffData),
        .firData      (firData),
        .firValid     (firValid),
        .busy         (busy),
        .overrun      (overrun),
        .overrunClear (overrunClear)
    );

    always #5 clk = ~clk;

    assign coeffData = (coeffAddr < 3'd5) ? bank[coeffAddr] : 16'sd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sampleValid  = 1'b0;
        sampleIn     = '0;
        overrunClear = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic set_bank(input logic [15:0] c0, c1, c2, c3, c4);
        bank[0] = c0; bank[1] = c1; bank[2] = c2; bank[3] = c3; bank[4] = c4;
    endtask

    // Steps until firValid (bounded), captures firData, then returns to IDLE.
    task automatic wait_result(output logic [15:0] y);
        logic got = 1'b0;
        y = 'x;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (firValid === 1'b1) begin
                y   = firData;
                got = 1'b1;
            end
        end
        check("result_timeout", {31'd0, got}, 32'd1);
        step();
    endtask

    task automatic run_sample(input logic [15:0] x, output logic [15:0] y);
        sampleIn    = x;
        sampleValid = 1'b1;
        step();
        sampleValid = 1'b0;
        wait_result(y);
    endtask

    task automatic impulse_test(input string tag);
        logic [15:0] y;
        set_bank(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        for (int i = 0; i < 6; i++) begin
            run_sample((i == 0) ? 16'h4000 : 16'h0000, y);
            check($sformatf("%s_out%0d", tag, i), {16'd0, y}, (i < 5) ? 32'h2000 : 32'h0000);
        end
    endtask

    initial begin
        logic [15:0] y;
        logic        seen;

        // Reset values
        do_reset();
        check("rst_firData", {16'd0, firData}, 32'd0);
        check("rst_firValid", {31'd0, firValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_coeffAddr", {29'd0, coeffAddr}, 32'd0);

        impulse_test("impulse");

        // Timing: strobe captured at edge t, then observe cycles t+1..t+7
        do_reset();
        set_bank(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        sampleIn    = 16'h4000;
        sampleValid = 1'b1;
        step();
        sampleValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("tim_busy_%0d", k), {31'd0, busy}, 32'd1);
            check($sformatf("tim_addr_%0d", k), {29'd0, coeffAddr}, k);
            check($sformatf("tim_valid_lo_%0d", k), {31'd0, firValid}, 32'd0);
            step();
        end
        check("tim_valid_hi", {31'd0, firValid}, 32'd1);
        check("tim_busy_done", {31'd0, busy}, 32'd1);
        check("tim_data", {16'd0, firData}, 32'h2000);
        step();
        check("tim_valid_after", {31'd0, firValid}, 32'd0);
        check("tim_busy_after", {31'd0, busy}, 32'd0);
        check("tim_data_held", {16'd0, firData}, 32'h2000);

        // Overrun: a sample arriving mid-MAC is dropped and sets the sticky flag
        sampleIn    = 16'h0000;
        sampleValid = 1'b1;
        step();
        sampleValid = 1'b0;
        step();
        sampleIn    = 16'h7000;
        sampleValid = 1'b1;
        step();
        sampleValid = 1'b0;
        check("ovr_set", {31'd0, overrun}, 32'd1);
        wait_result(y);
        check("ovr_out_unchanged", {16'd0, y}, 32'h2000);
        run_sample(16'h0000, y);
        check("ovr_hist_unchanged", {16'd0, y}, 32'h2000);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        overrunClear = 1'b1;
        step();
        overrunClear = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Set and clear in the same cycle: set wins
        sampleIn    = 16'h0000;
        sampleValid = 1'b1;
        step();
        overrunClear = 1'b1;
        step();
        sampleValid  = 1'b0;
        overrunClear = 1'b0;
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        wait_result(y);
        overrunClear = 1'b1;
        step();
        overrunClear = 1'b0;
        check("ovr_cleared2", {31'd0, overrun}, 32'd0);

        // Pointer wrap: only tap 2 nonzero, output is the sample two frames back halved
        do_reset();
        set_bank(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
        for (int i = 0; i < 7; i++) begin
            run_sample(16'(2 * (i + 1)), y);
            check($sformatf("wrap_out%0d", i), {16'd0, y}, (i < 2) ? 32'd0 : 32'(i - 1));
        end

        // Reset mid-MAC aborts the operation and clears overrun
        do_reset();
        set_bank(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        sampleIn    = 16'h4000;
        sampleValid = 1'b1;
        step();
        step();
        sampleValid = 1'b0;
        check("rmid_overrun_pre", {31'd0, overrun}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_overrun", {31'd0, overrun}, 32'd0);
        check("rmid_firValid", {31'd0, firValid}, 32'd0);
        check("rmid_coeffAddr", {29'd0, coeffAddr}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (firValid !== 1'b0) seen = 1'b1;
        end
        check("rmid_no_firValid", {31'd0, seen}, 32'd0);
        impulse_test("rmid_impulse");

        // Saturation / wrap of the final result
        do_reset();
        set_bank(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 5; i++) begin
            run_sample(16'h7FFF, y);
            if (i == 0) check("sat_first", {16'd0, y}, 32'h7FFE);
        end
`ifdef FIR_SATURATE_EN
        check("sat_pos", {16'd0, y}, 32'h7FFF);
`else
        check("sat_pos", {16'd0, y}, 32'h7FF6);
`endif
        for (int i = 0; i < 5; i++) begin
            run_sample(16'h8000, y);
        end
`ifdef FIR_SATURATE_EN
        check("sat_neg", {16'd0, y}, 32'h8000);
`else
        check("sat_neg", {16'd0, y}, 32'h8005);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
